// File: rtl/lsu_split_ctrl.sv
// lsu_split_ctrl: load/store unit between the single-cycle core and data memory.
// One outstanding access on a req/gnt/rvalid handshake with variable latency,
// sign/zero-extended load return and a per-beat response timeout.
// Optional feature macro: LSU_MISALIGN_EN. When it is defined, misaligned H/W
// accesses that cross a word boundary are split into two memory beats.
// When it is undefined, such accesses fault without touching memory.
module lsu_split_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_adr_i,
  input  logic [31:0]       lsu_data_i,
  output logic              lsu_stall_req_o,
  output logic [31:0]       lsu_data_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_adr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RSP0 = 3'd2,
    S_REQ1 = 3'd3,
    S_RSP1 = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 2);
  localparam int                TO_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam bit                TO_EN     = (TIMEOUT_CYC > 0);

  // Legal funct3 sizes: B, H, W, BU, HU.
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_legal = 1'b1;
      default:                                size_legal = 1'b0;
    endcase
  endfunction

  // Sign- or zero-extend the low byte/half of an extracted load word.
  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [31:0] w);
    case (size)
      3'b000:  load_ext = {{24{w[7]}}, w[7:0]};
      3'b001:  load_ext = {{16{w[15]}}, w[15:0]};
      3'b100:  load_ext = {24'h000000, w[7:0]};
      3'b101:  load_ext = {16'h0000, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] acc_adr_q, acc_adr_d;
  logic [2:0]        acc_size_q, acc_size_d;
  logic              acc_we_q, acc_we_d;
  logic [31:0]       acc_data_q, acc_data_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic              discard_q, discard_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              err_out_q, err_out_d;

  logic [ADDR_W-1:0] src_adr_s;
  logic [2:0]        src_size_s;
  logic              src_we_s;
  logic [31:0]       src_data_s;
  logic [1:0]        off_s;
  logic              is_h_s, is_w_s;
  logic              split_s, misalign_bad_s, access_ok_s;
  logic [3:0]        mask_s;
  logic [7:0]        be8_s;
  logic [63:0]       wd64_s;
  logic              beat1_s;
  logic [ADDR_W-1:0] word_adr_s;
  logic [31:0]       ld_lo_s;
  logic [23:0]       ld_hi_s;
  logic [31:0]       ld_word_s;
  logic              issue_s;
  logic              discard_now_s;
  logic              to_hit_s;

  // In IDLE the access is decoded straight from the core; afterwards from the captured copy,
  // so memory outputs stay stable even if the core withdraws the request.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_adr_s  = lsu_adr_i;
      src_size_s = lsu_size_i;
      src_we_s   = lsu_we_i;
      src_data_s = lsu_data_i;
    end else begin
      src_adr_s  = acc_adr_q;
      src_size_s = acc_size_q;
      src_we_s   = acc_we_q;
      src_data_s = acc_data_q;
    end
  end

  // Decode size/offset into legality, split need, lane masks and lane-aligned write data.
  always_comb begin
    off_s  = src_adr_s[1:0];
    is_h_s = (src_size_s[1:0] == 2'b01);
    is_w_s = (src_size_s == 3'b010);
`ifdef LSU_MISALIGN_EN
    split_s        = (is_h_s && (off_s == 2'd3)) || (is_w_s && (off_s != 2'd0));
    misalign_bad_s = 1'b0;
`else
    split_s        = 1'b0;
    misalign_bad_s = (is_h_s && off_s[0]) || (is_w_s && (off_s != 2'd0));
`endif
    access_ok_s = size_legal(src_size_s) && !misalign_bad_s;
    if (is_w_s) begin
      mask_s = 4'b1111;
    end else if (is_h_s) begin
      mask_s = 4'b0011;
    end else begin
      mask_s = 4'b0001;
    end
    be8_s      = {4'b0000, mask_s} << off_s;
    wd64_s     = {32'h0000_0000, src_data_s} << {off_s, 3'b000};
    beat1_s    = (state_q == S_REQ1) || (state_q == S_RSP1);
    word_adr_s = {src_adr_s[ADDR_W-1:2], 2'b00};
  end

  // Memory request and its payload; everything reads as zero while no request is raised.
  always_comb begin
    issue_s    = (state_q == S_IDLE) && lsu_req_i && access_ok_s;
    data_req_o = !rst_i && (issue_s || (state_q == S_REQ0) || (state_q == S_REQ1));
    if (data_req_o) begin
      data_we_o    = src_we_s;
      data_be_o    = beat1_s ? be8_s[7:4] : be8_s[3:0];
      data_adr_o   = beat1_s ? (word_adr_s + WORD_STEP) : word_adr_s;
      data_wdata_o = beat1_s ? wd64_s[63:32] : wd64_s[31:0];
    end else begin
      data_we_o    = 1'b0;
      data_be_o    = 4'b0000;
      data_adr_o   = '0;
      data_wdata_o = 32'h0000_0000;
    end
  end

  // Reassemble the load word: beat 0 alone, or beat-0 upper lanes joined with beat-1 lower lanes.
  always_comb begin
    if (beat1_s) begin
      ld_lo_s = rdata0_q;
      ld_hi_s = data_rdata_i[23:0];
    end else begin
      ld_lo_s = data_rdata_i;
      ld_hi_s = 24'h000000;
    end
    case (off_s)
      2'd0:    ld_word_s = ld_lo_s;
      2'd1:    ld_word_s = {ld_hi_s[7:0],  ld_lo_s[31:8]};
      2'd2:    ld_word_s = {ld_hi_s[15:0], ld_lo_s[31:16]};
      2'd3:    ld_word_s = {ld_hi_s[23:0], ld_lo_s[31:24]};
      default: ld_word_s = ld_lo_s;
    endcase
  end

  // Stall the core until the DONE cycle; never while reset is held.
  always_comb begin
    lsu_stall_req_o = !rst_i && lsu_req_i && (state_q != S_DONE);
    lsu_data_o      = data_out_q;
    lsu_err_o       = err_out_q;
  end

  // Access sequencing: next state, timeout counting, capture of access and read data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_adr_d  = acc_adr_q;
    acc_size_d = acc_size_q;
    acc_we_d   = acc_we_q;
    acc_data_d = acc_data_q;
    rdata0_d   = rdata0_q;
    discard_d  = discard_q;
    data_out_d = 32'h0000_0000;
    err_out_d  = 1'b0;
    discard_now_s = discard_q || !lsu_req_i;
    to_hit_s      = TO_EN && (cnt_q == TO_LAST);
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (!access_ok_s) begin
            state_d   = S_DONE;
            err_out_d = 1'b1;
          end else begin
            acc_adr_d  = lsu_adr_i;
            acc_size_d = lsu_size_i;
            acc_we_d   = lsu_we_i;
            acc_data_d = lsu_data_i;
            rdata0_d   = 32'h0000_0000;
            discard_d  = 1'b0;
            cnt_d      = '0;
            state_d    = data_gnt_i ? S_RSP0 : S_REQ0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ0, S_REQ1: begin
        discard_d = discard_now_s;
        if (data_gnt_i) begin
          state_d = (state_q == S_REQ0) ? S_RSP0 : S_RSP1;
          cnt_d   = '0;
        end else if (to_hit_s) begin
          state_d   = discard_now_s ? S_IDLE : S_DONE;
          err_out_d = !discard_now_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RSP0, S_RSP1: begin
        discard_d = discard_now_s;
        if (data_rvalid_i) begin
          if (discard_now_s) begin
            state_d = S_IDLE;
          end else if ((state_q == S_RSP0) && split_s) begin
            state_d  = S_REQ1;
            rdata0_d = data_rdata_i;
            cnt_d    = '0;
          end else begin
            state_d    = S_DONE;
            data_out_d = acc_we_q ? 32'h0000_0000 : load_ext(acc_size_q, ld_word_s);
          end
        end else if (to_hit_s) begin
          state_d   = discard_now_s ? S_IDLE : S_DONE;
          err_out_d = !discard_now_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any access immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_adr_q  <= '0;
      acc_size_q <= 3'b000;
      acc_we_q   <= 1'b0;
      acc_data_q <= 32'h0000_0000;
      rdata0_q   <= 32'h0000_0000;
      discard_q  <= 1'b0;
      data_out_q <= 32'h0000_0000;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_adr_q  <= acc_adr_d;
      acc_size_q <= acc_size_d;
      acc_we_q   <= acc_we_d;
      acc_data_q <= acc_data_d;
      rdata0_q   <= rdata0_d;
      discard_q  <= discard_d;
      data_out_q <= data_out_d;
      err_out_q  <= err_out_d;
    end
  end

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Self-checking bench for lsu_split_ctrl: directed scenarios plus randomized
// accesses checked cycle by cycle against a byte-level reference model.
module tb_lsu_split_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_adr_i, lsu_data_i;
  logic        lsu_stall_req_o;
  logic [31:0] lsu_data_o;
  logic        lsu_err_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_adr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_data, obs_adr0, obs_adr1, obs_wd0;
  logic [3:0]  obs_be0, obs_be1;
  logic        obs_err;
  int          obs_stall;

  lsu_split_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_adr_i(lsu_adr_i), .lsu_data_i(lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_adr_o(data_adr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: which lanes of which word each access byte touches.
  task automatic model(input logic we, input logic [2:0] size, input logic [31:0] adr,
                       input logic [31:0] data, input logic [31:0] rd0, input logic [31:0] rd1,
                       output bit legal, output int nb,
                       output logic [3:0] be0, output logic [3:0] be1,
                       output logic [31:0] a0, output logic [31:0] a1,
                       output logic [31:0] w0, output logic [31:0] w1,
                       output logic [31:0] res);
    int n, off, pos;
    logic [31:0] val;
    off = int'(adr[1:0]);
    case (size)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    if (n == 0) legal = 1'b0;
`ifdef LSU_MISALIGN_EN
    else legal = 1'b1;
`else
    else legal = ((off % n) == 0);
`endif
    nb = (off + n > 4) ? 2 : 1;
    be0 = 4'h0; be1 = 4'h0; w0 = 32'h0; w1 = 32'h0;
    for (int i = 0; i < n; i++) begin
      pos = off + i;
      if (pos < 4) be0[pos] = 1'b1; else be1[pos-4] = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      pos = off + j;
      if (pos < 4) w0[8*pos +: 8] = data[8*j +: 8];
      else         w1[8*(pos-4) +: 8] = data[8*j +: 8];
    end
    a0 = adr & 32'hFFFF_FFFC;
    a1 = a0 + 32'd4;
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      pos = off + i;
      if (pos < 4) val[8*i +: 8] = rd0[8*pos +: 8];
      else         val[8*i +: 8] = rd1[8*(pos-4) +: 8];
    end
    if (n > 0 && n < 4 && !size[2] && val[8*n-1]) val = val - (32'd1 << (8*n));
    res = we ? 32'h0 : val;
  endtask

  // One access from IDLE to DONE; entered and left at posedge+1.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] adr,
                            input logic [31:0] data, input int gd0, input int rv0,
                            input int gd1, input int rv1,
                            input logic [31:0] rdw0, input logic [31:0] rdw1);
    bit legal; int nb, g, r;
    logic [3:0] be0, be1, ebe;
    logic [31:0] a0, a1, w0, w1, res, ea, ew;
    model(we, size, adr, data, rdw0, rdw1, legal, nb, be0, be1, a0, a1, w0, w1, res);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_adr_i = adr; lsu_data_i = data;
    obs_stall = 0;
    if (!legal) begin
      #3;
      chk("ill_req", 32'(data_req_o), 32'd0);
      chk("ill_stall", 32'(lsu_stall_req_o), 32'd1);
      obs_stall += int'(lsu_stall_req_o);
      @(posedge clk); #1;
    end else begin
      for (int b = 0; b < nb; b++) begin
        g = (b == 0) ? gd0 : gd1;
        r = (b == 0) ? rv0 : rv1;
        ebe = (b == 0) ? be0 : be1;
        ea  = (b == 0) ? a0 : a1;
        ew  = (b == 0) ? w0 : w1;
        for (int c = 0; c <= g; c++) begin
          #3;
          chk("req", 32'(data_req_o), 32'd1);
          chk("adr", data_adr_o, ea);
          chk("be", 32'(data_be_o), 32'(ebe));
          chk("we", 32'(data_we_o), 32'(we));
          if (we) chk("wdata", data_wdata_o, ew);
          chk("req_stall", 32'(lsu_stall_req_o), 32'd1);
          chk("req_data0", lsu_data_o, 32'd0);
          obs_stall += int'(lsu_stall_req_o);
          if (b == 0 && c == 0) begin
            obs_be0 = data_be_o; obs_adr0 = data_adr_o; obs_wd0 = data_wdata_o;
          end
          if (b == 1 && c == 0) begin
            obs_be1 = data_be_o; obs_adr1 = data_adr_o;
          end
          if (c == g) data_gnt_i = 1'b1;
          @(posedge clk); #1;
          data_gnt_i = 1'b0;
        end
        for (int c = 0; c <= r; c++) begin
          #3;
          chk("rsp_req", 32'(data_req_o), 32'd0);
          chk("rsp_be", 32'(data_be_o), 32'd0);
          chk("rsp_stall", 32'(lsu_stall_req_o), 32'd1);
          obs_stall += int'(lsu_stall_req_o);
          if (c == r) begin
            data_rvalid_i = 1'b1;
            data_rdata_i = (b == 0) ? rdw0 : rdw1;
          end else begin
            data_rdata_i = $urandom;
          end
          @(posedge clk); #1;
          data_rvalid_i = 1'b0;
          data_rdata_i = $urandom;
        end
      end
    end
    #3;
    chk("done_stall", 32'(lsu_stall_req_o), 32'd0);
    chk("done_req", 32'(data_req_o), 32'd0);
    chk("done_err", 32'(lsu_err_o), legal ? 32'd0 : 32'd1);
    chk("done_data", lsu_data_o, legal ? res : 32'd0);
    obs_data = lsu_data_o; obs_err = lsu_err_o;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    lsu_req_i = 1'b0;
    for (int c = 0; c < k; c++) begin
      #3;
      chk("idle_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("idle_req", 32'(data_req_o), 32'd0);
      chk("idle_data", lsu_data_o, 32'd0);
      chk("idle_err", 32'(lsu_err_o), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  logic [2:0] size_tab [12] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010,
                                3'b000, 3'b001, 3'b101, 3'b010, 3'b011, 3'b111};

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010;
    lsu_adr_i = 32'h100; lsu_data_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    #1;
    chk("rst_stall", 32'(lsu_stall_req_o), 32'd0);
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_data", lsu_data_o, 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    lsu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle(2);

    // LW aligned, minimum latency
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    chk("lw_data", obs_data, 32'hDEADBEEF);
    chk("lw_stalls", 32'(obs_stall), 32'd2);
    // LB / LBU top byte
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 0, 0, 32'h80112233, 32'h0);
    chk("lb_be", 32'(obs_be0), 32'h8);
    chk("lb_data", obs_data, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 1, 2, 0, 0, 32'h80112233, 32'h0);
    chk("lbu_data", obs_data, 32'h00000080);
    idle(1);
    // SH with delayed grant
    run_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 3, 0, 0, 0, 32'h0, 32'h0);
    chk("sh_adr", obs_adr0, 32'h100);
    chk("sh_be", 32'(obs_be0), 32'hC);
    chk("sh_wdata", obs_wd0, 32'hABCD0000);
    chk("sh_stalls", 32'(obs_stall), 32'd5);
    // LW misaligned
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 0, 0, 32'h44332211, 32'h88776655);
`ifdef LSU_MISALIGN_EN
    chk("mis_adr1", obs_adr1, 32'h104);
    chk("mis_be0", 32'(obs_be0), 32'hE);
    chk("mis_be1", 32'(obs_be1), 32'h1);
    chk("mis_data", obs_data, 32'h55443322);
`else
    chk("mis_err", 32'(obs_err), 32'd1);
    chk("mis_data", obs_data, 32'd0);
`endif
    idle(1);

    // Timeout: grant at once, never rvalid
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_adr_i = 32'h300;
    #3; chk("to_req", 32'(data_req_o), 32'd1); data_gnt_i = 1'b1;
    @(posedge clk); #1; data_gnt_i = 1'b0;
    for (int c = 0; c < TO; c++) begin
      #3; chk("to_wait_stall", 32'(lsu_stall_req_o), 32'd1);
      @(posedge clk); #1;
    end
    #3;
    chk("to_stall", 32'(lsu_stall_req_o), 32'd0);
    chk("to_err", 32'(lsu_err_o), 32'd1);
    chk("to_data", lsu_data_o, 32'd0);
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
    #3; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
    @(posedge clk); #1; data_rvalid_i = 1'b0;
    idle(1);
    run_access(1'b0, 3'b001, 32'h302, 32'h0, 0, 1, 0, 0, 32'h7FFF0000, 32'h0);
    chk("after_to_data", obs_data, 32'h00007FFF);

    // Reset while in RSP0
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_adr_i = 32'h200;
    #3; data_gnt_i = 1'b1;
    @(posedge clk); #1; data_gnt_i = 1'b0;
    #3; chk("rsp0_stall", 32'(lsu_stall_req_o), 32'd1);
    rst_i = 1'b1; #1;
    chk("arst_rsp_stall", 32'(lsu_stall_req_o), 32'd0);
    chk("arst_rsp_req", 32'(data_req_o), 32'd0);
    chk("arst_rsp_data", lsu_data_o, 32'd0);
    @(posedge clk); #1; rst_i = 1'b0;
    idle(1);
    // Reset while holding a request in REQ0
    lsu_req_i = 1'b1;
    #3; chk("req0_req_a", 32'(data_req_o), 32'd1);
    @(posedge clk); #1;
    #3; chk("req0_req_b", 32'(data_req_o), 32'd1);
    rst_i = 1'b1; #1;
    chk("arst_req_req", 32'(data_req_o), 32'd0);
    chk("arst_req_stall", 32'(lsu_stall_req_o), 32'd0);
    @(posedge clk); #1; rst_i = 1'b0;
    idle(1);
    run_access(1'b0, 3'b010, 32'h204, 32'h0, 1, 1, 0, 0, 32'hCAFEF00D, 32'h0);
    chk("after_rst_data", obs_data, 32'hCAFEF00D);

    // Request withdrawn while waiting for grant: beat completes, no DONE
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'b010; lsu_adr_i = 32'h400;
    lsu_data_i = 32'h11223344;
    #3; @(posedge clk); #1;
    lsu_req_i = 1'b0; lsu_adr_i = 32'h0; lsu_data_i = 32'h0;
    #3;
    chk("drop_req", 32'(data_req_o), 32'd1);
    chk("drop_adr", data_adr_o, 32'h400);
    chk("drop_wdata", data_wdata_o, 32'h11223344);
    chk("drop_stall", 32'(lsu_stall_req_o), 32'd0);
    data_gnt_i = 1'b1;
    @(posedge clk); #1; data_gnt_i = 1'b0;
    #3; chk("drop_rsp_req", 32'(data_req_o), 32'd0); data_rvalid_i = 1'b1;
    @(posedge clk); #1; data_rvalid_i = 1'b0;
    idle(2);
    run_access(1'b0, 3'b000, 32'h401, 32'h0, 0, 0, 0, 0, 32'h00007F00, 32'h0);
    chk("after_drop_data", obs_data, 32'h0000007F);

    // Randomized accesses, some back-to-back
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = $urandom;
      if (t % 10 == 0) a[31:2] = 30'h3FFFFFFF;
      run_access(1'($urandom_range(0, 1)), size_tab[$urandom_range(0, 11)], a, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
